// File: rtl/michi_board_ctrl.sv
// Michi (tic-tac-toe) game-state stage: accepts moves, keeps the X/O occupancy
// maps and the turn, and registers its own win/draw verdict.
module michi_board_ctrl #(
  parameter bit FIRST_PLAYER    = 1'b0,
  parameter bit ALTERNATE_START = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       MOVE_REQ,
  input  logic [3:0] MOVE_CELL,
  input  logic       NEW_GAME,
  output logic [8:0] BOARD_X,
  output logic [8:0] BOARD_O,
  output logic       TURN,
  output logic       MOVE_ACK,
  output logic       MOVE_NAK,
  output logic       WIN_X,
  output logic       WIN_O,
  output logic       DRAW,
  output logic       GAME_OVER
);

  typedef enum logic [1:0] {
    S_PLAY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       req_q;
  logic       start_q, start_d;
  logic [3:0] cnt_q, cnt_d;

  logic [8:0] bx_d, bo_d;
  logic       turn_d, ack_d, nak_d, wx_d, wo_d, draw_d;

  logic       ev;
  logic       cell_ok;
  logic [8:0] cell_bit;
  logic       occupied;
  logic [8:0] mover_map;

  function automatic logic has_line(input logic [8:0] m);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  assign ev        = MOVE_REQ & ~req_q;
  assign cell_ok   = (MOVE_CELL <= 4'd8);
  assign cell_bit  = cell_ok ? (9'd1 << MOVE_CELL) : '0;
  assign occupied  = |(cell_bit & (BOARD_X | BOARD_O));
  // TURN still names the player who just moved while in CHECK
  assign mover_map = TURN ? BOARD_O : BOARD_X;

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    bx_d    = BOARD_X;
    bo_d    = BOARD_O;
    turn_d  = TURN;
    ack_d   = 1'b0;
    nak_d   = 1'b0;
    wx_d    = WIN_X;
    wo_d    = WIN_O;
    draw_d  = DRAW;

    if (NEW_GAME) begin
      state_d = S_PLAY;
      cnt_d   = '0;
      bx_d    = '0;
      bo_d    = '0;
      wx_d    = 1'b0;
      wo_d    = 1'b0;
      draw_d  = 1'b0;
      start_d = ALTERNATE_START ? ~start_q : start_q;
      turn_d  = start_d;
    end else begin
      unique case (state_q)
        S_PLAY: begin
          if (ev) begin
            if (cell_ok && !occupied) begin
              if (TURN) bo_d = BOARD_O | cell_bit;
              else      bx_d = BOARD_X | cell_bit;
              cnt_d   = cnt_q + 4'd1;
              ack_d   = 1'b1;
              state_d = S_CHECK;
            end else begin
              nak_d = 1'b1;
            end
          end
        end
        S_CHECK: begin
          nak_d = ev;
          if (has_line(mover_map)) begin
            if (TURN) wo_d = 1'b1;
            else      wx_d = 1'b1;
            state_d = S_DONE;
          end else if (cnt_q == 4'd9) begin
            draw_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            turn_d  = ~TURN;
            state_d = S_PLAY;
          end
        end
        S_DONE: begin
          nak_d = ev;
        end
        default: state_d = S_PLAY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_PLAY;
      req_q     <= 1'b0;
      start_q   <= FIRST_PLAYER;
      cnt_q     <= '0;
      BOARD_X   <= '0;
      BOARD_O   <= '0;
      TURN      <= FIRST_PLAYER;
      MOVE_ACK  <= 1'b0;
      MOVE_NAK  <= 1'b0;
      WIN_X     <= 1'b0;
      WIN_O     <= 1'b0;
      DRAW      <= 1'b0;
      GAME_OVER <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= MOVE_REQ;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      BOARD_X   <= bx_d;
      BOARD_O   <= bo_d;
      TURN      <= turn_d;
      MOVE_ACK  <= ack_d;
      MOVE_NAK  <= nak_d;
      WIN_X     <= wx_d;
      WIN_O     <= wo_d;
      DRAW      <= draw_d;
      GAME_OVER <= wx_d | wo_d | draw_d;
    end
  end

endmodule

// File: tb/tb_michi_board_ctrl.sv
// Bench for michi_board_ctrl: cell-array game model compared against every
// output after each clock, directed game scenarios plus randomized play.
module tb_michi_board_ctrl;

  localparam bit FP  = 1'b0;
  localparam bit ALT = 1'b1;

  logic       CLK, RST_N, MOVE_REQ, NEW_GAME;
  logic [3:0] MOVE_CELL;
  logic [8:0] BOARD_X, BOARD_O;
  logic       TURN, MOVE_ACK, MOVE_NAK, WIN_X, WIN_O, DRAW, GAME_OVER;

  michi_board_ctrl #(.FIRST_PLAYER(FP), .ALTERNATE_START(ALT)) dut (
    .CLK(CLK), .RST_N(RST_N), .MOVE_REQ(MOVE_REQ), .MOVE_CELL(MOVE_CELL),
    .NEW_GAME(NEW_GAME), .BOARD_X(BOARD_X), .BOARD_O(BOARD_O), .TURN(TURN),
    .MOVE_ACK(MOVE_ACK), .MOVE_NAK(MOVE_NAK), .WIN_X(WIN_X), .WIN_O(WIN_O),
    .DRAW(DRAW), .GAME_OVER(GAME_OVER)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // model: cell contents 0 = empty, 1 = X, 2 = O
  int m_cell[9];
  bit m_turn, m_start, m_wx, m_wo, m_draw, m_ack, m_nak, m_pending, m_req_prev;
  int m_moves;

  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit model_line(input int p);
    for (int i = 0; i < 8; i++)
      if (m_cell[lines[i][0]] == p && m_cell[lines[i][1]] == p && m_cell[lines[i][2]] == p)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_turn = FP; m_start = FP; m_wx = 0; m_wo = 0; m_draw = 0;
    m_ack = 0; m_nak = 0; m_pending = 0; m_req_prev = 0; m_moves = 0;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] c, input logic g);
    bit ev;
    ev = r && !m_req_prev;
    m_req_prev = r;
    m_ack = 0;
    m_nak = 0;
    if (g) begin
      for (int i = 0; i < 9; i++) m_cell[i] = 0;
      m_moves = 0; m_wx = 0; m_wo = 0; m_draw = 0; m_pending = 0;
      if (ALT) m_start = !m_start;
      m_turn = m_start;
    end else if (m_pending) begin
      // verdict on the move accepted at the previous edge
      m_pending = 0;
      if (model_line(m_turn ? 2 : 1)) begin
        if (m_turn) m_wo = 1; else m_wx = 1;
      end else if (m_moves == 9) m_draw = 1;
      else m_turn = !m_turn;
      m_nak = ev;
    end else if (m_wx || m_wo || m_draw) begin
      m_nak = ev;
    end else if (ev) begin
      if (c <= 8) begin
        if (m_cell[c] == 0) begin
          m_cell[c] = m_turn ? 2 : 1;
          m_moves++;
          m_ack = 1;
          m_pending = 1;
        end else m_nak = 1;
      end else m_nak = 1;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all();
    logic [8:0] ex, eo;
    ex = '0; eo = '0;
    for (int i = 0; i < 9; i++) begin
      ex[i] = (m_cell[i] == 1);
      eo[i] = (m_cell[i] == 2);
    end
    cmp("board_x", 32'(BOARD_X), 32'(ex));
    cmp("board_o", 32'(BOARD_O), 32'(eo));
    cmp("turn", 32'(TURN), 32'(m_turn));
    cmp("ack", 32'(MOVE_ACK), 32'(m_ack));
    cmp("nak", 32'(MOVE_NAK), 32'(m_nak));
    cmp("win_x", 32'(WIN_X), 32'(m_wx));
    cmp("win_o", 32'(WIN_O), 32'(m_wo));
    cmp("draw", 32'(DRAW), 32'(m_draw));
    cmp("game_over", 32'(GAME_OVER), 32'(m_wx | m_wo | m_draw));
    cmp("ack_nak_excl", 32'(MOVE_ACK & MOVE_NAK), 32'd0);
    cmp("map_overlap", 32'(BOARD_X & BOARD_O), 32'd0);
  endtask

  task automatic step(input logic r, input logic [3:0] c, input logic g);
    MOVE_REQ = r; MOVE_CELL = c; NEW_GAME = g;
    @(posedge CLK);
    model_edge(r, c, g);
    #1;
    check_all();
  endtask

  task automatic play(input logic [3:0] c, output logic ack, output logic nak);
    step(1'b1, c, 1'b0);
    ack = MOVE_ACK; nak = MOVE_NAK;
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic mid_reset();
    #3 RST_N = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 RST_N = 1'b1;
  endtask

  logic a, n;
  int   acks, naks;
  int   seqx[9] = '{4, 0, 2, 6, 3, 5, 8, 7, 1};
  int   g1[5]   = '{0, 3, 1, 4, 2};

  initial begin
    RST_N = 1'b0; MOVE_REQ = 0; MOVE_CELL = 0; NEW_GAME = 0;
    model_reset();
    #12;
    check_all();
    cmp("lit_reset_turn", 32'(TURN), 32'(FP));
    RST_N = 1'b1;

    // X wins on the top row
    for (int i = 0; i < 5; i++) begin
      play(4'(g1[i]), a, n);
      cmp("lit_g1_ack", 32'(a), 32'd1);
    end
    cmp("lit_g1_bx", 32'(BOARD_X), 32'h007);
    cmp("lit_g1_bo", 32'(BOARD_O), 32'h018);
    cmp("lit_g1_winx", 32'(WIN_X), 32'd1);
    play(4'd5, a, n);
    cmp("lit_done_nak", 32'(n), 32'd1);

    // NEW_GAME with a coincident request; start alternates
    step(1'b1, 4'd4, 1'b1);
    cmp("lit_ng_board", 32'(BOARD_X | BOARD_O), 32'd0);
    cmp("lit_ng_acknak", 32'(MOVE_ACK | MOVE_NAK), 32'd0);
    cmp("lit_ng_turn1", 32'(TURN), 32'd1);
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    cmp("lit_ng_turn0", 32'(TURN), 32'd0);

    // full board without a line
    for (int i = 0; i < 9; i++) play(4'(seqx[i]), a, n);
    cmp("lit_draw", 32'(DRAW), 32'd1);
    cmp("lit_draw_wins", 32'(WIN_X | WIN_O), 32'd0);
    cmp("lit_draw_full", 32'(BOARD_X | BOARD_O), 32'h1FF);

    // occupied and out-of-range cells
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    play(4'd4, a, n);
    play(4'd4, a, n);
    cmp("lit_occ_nak", 32'(n), 32'd1);
    cmp("lit_occ_bo", 32'(BOARD_O), 32'd0);
    cmp("lit_occ_turn", 32'(TURN), 32'd1);
    play(4'd9, a, n);
    cmp("lit_nine_nak", 32'(n), 32'd1);
    play(4'd15, a, n);
    cmp("lit_fifteen_nak", 32'(n), 32'd1);

    // held request yields one move; holding through CHECK adds nothing
    acks = 0; naks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'd0, 1'b0);
      acks += int'(MOVE_ACK);
      naks += int'(MOVE_NAK);
    end
    step(1'b0, 4'd0, 1'b0);
    cmp("lit_hold_acks", 32'(acks), 32'd1);
    cmp("lit_hold_naks", 32'(naks), 32'd0);

    // asynchronous reset while in CHECK
    step(1'b1, 4'd2, 1'b0);
    mid_reset();
    cmp("lit_areset_board", 32'(BOARD_X | BOARD_O), 32'd0);
    cmp("lit_areset_ack", 32'(MOVE_ACK), 32'd0);
    play(4'd0, a, n);
    cmp("lit_resume_ack", 32'(a), 32'd1);
    cmp("lit_resume_bx", 32'(BOARD_X), 32'h001);

    // randomized play
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [3:0] c;
      r = $urandom_range(0, 199);
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      if (r == 0) mid_reset();
      else step(1'($urandom_range(0, 1)), c, (r < 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
